// File: rtl/uart_rx_wr.sv
// uart_rx_wr: 16x-oversampling UART receiver that writes each valid frame into the RX FIFO memory.
// Optional even-parity checking with a parity_err pulse is enabled by defining UART_RX_PARITY_EN.
module uart_rx_wr #(
  parameter int DATASIZE = 8,
  parameter int BAUD_DIV = 16
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                rxd,
  input  logic                wfull,
  output logic [DATASIZE-1:0] wdata,
  output logic                wclken,
  output logic                frame_err,
  output logic                overrun,
`ifdef UART_RX_PARITY_EN
  output logic                parity_err,
`endif
  output logic                busy
);
  localparam int PW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
`endif
  state_t              state_q, state_d;
  logic                rxd_m_q, rxd_s_q;
  logic [PW-1:0]       pre_q, pre_d;
  logic [3:0]          tcnt_q, tcnt_d;
  logic [2:0]          bcnt_q, bcnt_d;
  logic [DATASIZE-1:0] sh_q, sh_d, wdata_q, wdata_d;
  logic                wclken_q, wclken_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic                tick, mid;
`ifdef UART_RX_PARITY_EN
  logic                pbad_q, pbad_d, perr_q, perr_d;
`endif
  assign tick = pre_q == PW'(BAUD_DIV - 1);
  // 16 ticks per bit: tick count 15 lands on the bit midpoint once START has realigned the phase
  assign mid  = tick && tcnt_q == 4'd15;
  always_comb begin
    state_d  = state_q;
    pre_d    = tick ? '0 : pre_q + 1'b1;
    tcnt_d   = tick ? tcnt_q + 4'd1 : tcnt_q;
    bcnt_d   = bcnt_q;
    sh_d     = sh_q;
    wdata_d  = wdata_q;
    wclken_d = 1'b0;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d   = pbad_q;
    perr_d   = 1'b0;
`endif
    case (state_q)
      IDLE: if (!rxd_s_q) begin
        state_d = START;
        tcnt_d  = '0;
        pre_d   = '0;
      end
      START: if (tick && tcnt_q == 4'd7) begin
        state_d = rxd_s_q ? IDLE : DATA;
        tcnt_d  = '0;
        bcnt_d  = '0;
      end
      DATA: if (mid) begin
        sh_d   = {rxd_s_q, sh_q[DATASIZE-1:1]};
        bcnt_d = bcnt_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        state_d = (bcnt_q == 3'(DATASIZE - 1)) ? PARITY : DATA;
`else
        state_d = (bcnt_q == 3'(DATASIZE - 1)) ? STOP : DATA;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (mid) begin
        pbad_d  = rxd_s_q ^ (^sh_q);
        state_d = STOP;
      end
`endif
      STOP: if (mid) begin
        state_d = rxd_s_q ? IDLE : BRK;
        ferr_d  = !rxd_s_q;
`ifdef UART_RX_PARITY_EN
        perr_d   = rxd_s_q && pbad_q;
        ovr_d    = rxd_s_q && !pbad_q && wfull;
        wclken_d = rxd_s_q && !pbad_q && !wfull;
`else
        ovr_d    = rxd_s_q && wfull;
        wclken_d = rxd_s_q && !wfull;
`endif
        wdata_d = wclken_d ? sh_q : wdata_q;
      end
      BRK: state_d = rxd_s_q ? IDLE : BRK;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q  <= IDLE;
      rxd_m_q  <= 1'b1;
      rxd_s_q  <= 1'b1;
      pre_q    <= '0;
      tcnt_q   <= '0;
      bcnt_q   <= '0;
      sh_q     <= '0;
      wdata_q  <= '0;
      wclken_q <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_q   <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rxd_m_q  <= rxd;
      rxd_s_q  <= rxd_m_q;
      pre_q    <= pre_d;
      tcnt_q   <= tcnt_d;
      bcnt_q   <= bcnt_d;
      sh_q     <= sh_d;
      wdata_q  <= wdata_d;
      wclken_q <= wclken_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
`ifdef UART_RX_PARITY_EN
      pbad_q   <= pbad_d;
      perr_q   <= perr_d;
`endif
    end
  end
  assign wdata     = wdata_q;
  assign wclken    = wclken_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = state_q != IDLE;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif
endmodule
